// File: rtl/lut_scan_rom.sv
// Registered, writable lookup table with a default constant pattern
// and a burst-scan mode that streams consecutive entries with wrap.
module lut_scan_rom #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] Address,
    input  logic [DW-1:0] Din,
    input  logic          rd_en,
    input  logic          scan_start,
    input  logic [AW:0]   scan_len,
    input  logic          hold,
    output logic [DW-1:0] Y,
    output logic          valid,
    output logic          done,
    output logic          busy
);

    localparam int DEPTH = 2 ** AW;

    localparam logic [3:0] PAT [16] = '{
        4'hC, 4'h2, 4'h9, 4'hA, 4'h7, 4'h1, 4'hC, 4'h0,
        4'hF, 4'h1, 4'h3, 4'hD, 4'h8, 4'hE, 4'hA, 4'h6
    };

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]    state;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ptr;
    logic [AW:0]   rem;
    logic [AW:0]   len;

    // A zero length requests the whole table.
    assign len  = (scan_len == '0) ? (AW+1)'(DEPTH) : scan_len;
    assign busy = (state == SCAN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            rem   <= '0;
            Y     <= '0;
            valid <= 1'b0;
            done  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DW'(PAT[i[3:0]]);
            end
        end else begin
            valid <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (scan_start) begin
                        Y     <= mem[Address];
                        valid <= 1'b1;
                        ptr   <= Address + AW'(1);
                        rem   <= len - (AW+1)'(1);
                        if (len == (AW+1)'(1)) begin
                            done <= 1'b1;
                        end else begin
                            state <= SCAN;
                        end
                    end else begin
                        if (we) begin
                            mem[Address] <= Din;
                        end
                        // Same-cycle write and read returns the new data.
                        if (rd_en) begin
                            Y     <= we ? Din : mem[Address];
                            valid <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (!hold) begin
                        Y     <= mem[ptr];
                        valid <= 1'b1;
                        ptr   <= ptr + AW'(1);
                        rem   <= rem - (AW+1)'(1);
                        if (rem == (AW+1)'(1)) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_scan_rom.sv
// Self-checking bench for lut_scan_rom: directed scenarios plus
// randomized traffic against a plain array model of the table.
module tb_lut_scan_rom;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic [3:0] Address;
    logic [3:0] Din;
    logic       rd_en;
    logic       scan_start;
    logic [4:0] scan_len;
    logic       hold;
    logic [3:0] Y;
    logic       valid;
    logic       done;
    logic       busy;

    int passed;
    int total;

    logic [3:0] model [16];
    logic [3:0] defpat [16];

    lut_scan_rom #(.AW(4), .DW(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .we(we),
        .Address(Address),
        .Din(Din),
        .rd_en(rd_en),
        .scan_start(scan_start),
        .scan_len(scan_len),
        .hold(hold),
        .Y(Y),
        .valid(valid),
        .done(done),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_default();
        defpat = '{4'hC, 4'h2, 4'h9, 4'hA, 4'h7, 4'h1, 4'hC, 4'h0,
                   4'hF, 4'h1, 4'h3, 4'hD, 4'h8, 4'hE, 4'hA, 4'h6};
        for (int i = 0; i < 16; i++) model[i] = defpat[i];
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({Y, valid, done, busy} !== 7'b0)
            $display("FAIL reset_outputs got Y=%h v=%b d=%b b=%b want all 0",
                     Y, valid, done, busy);
        else passed++;
        load_default();
        cyc();
        cyc();
        #2;
        rst_n = 1'b1;
        cyc();
        total++;
        if (valid !== 1'b0 || Y !== 4'h0)
            $display("FAIL reset_idle got Y=%h v=%b want 0 0", Y, valid);
        else passed++;
    endtask

    task automatic test_read();
        Address = 4'd3;
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        total++;
        if (valid !== 1'b1 || Y !== 4'hA)
            $display("FAIL read3 got Y=%h v=%b want A 1", Y, valid);
        else passed++;
        cyc();
        total++;
        if (valid !== 1'b0 || Y !== 4'hA)
            $display("FAIL read3_pulse got Y=%h v=%b want A 0", Y, valid);
        else passed++;
    endtask

    task automatic test_write_read();
        Address = 4'd7;
        Din = 4'h5;
        we = 1'b1;
        cyc();
        we = 1'b0;
        model[7] = 4'h5;
        total++;
        if (valid !== 1'b0)
            $display("FAIL write_novalid got v=%b want 0", valid);
        else passed++;
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        total++;
        if (valid !== 1'b1 || Y !== 4'h5)
            $display("FAIL read7 got Y=%h v=%b want 5 1", Y, valid);
        else passed++;
        Address = 4'd2;
        Din = 4'hB;
        we = 1'b1;
        rd_en = 1'b1;
        cyc();
        we = 1'b0;
        rd_en = 1'b0;
        model[2] = 4'hB;
        total++;
        if (valid !== 1'b1 || Y !== 4'hB)
            $display("FAIL write_through got Y=%h v=%b want B 1", Y, valid);
        else passed++;
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        total++;
        if (Y !== 4'hB)
            $display("FAIL reread2 got Y=%h want B", Y);
        else passed++;
    endtask

    // Runs one scan; hold_n cycles of hold follow the word numbered
    // hold_after; wr_at >= 0 pulses a write to entry 5 during the scan.
    task automatic test_scan(input logic [3:0] addr, input int len_in,
                             input int hold_after, input int hold_n,
                             input int wr_at);
        int l;
        int got;
        int hold_left;
        int cycles;
        logic was_held;
        logic [3:0] exp_y;
        logic [3:0] last;
        l = (len_in == 0) ? 16 : len_in;
        Address = addr;
        scan_len = 5'(len_in);
        scan_start = 1'b1;
        hold = 1'b0;
        cyc();
        scan_start = 1'b0;
        got = 0;
        hold_left = 0;
        cycles = 0;
        was_held = 1'b0;
        last = 4'h0;
        while (got < l && cycles < 200) begin
            if (was_held) begin
                total++;
                if (valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || Y !== last)
                    $display("FAIL scan_hold got Y=%h v=%b d=%b b=%b want %h 0 0 1",
                             Y, valid, done, busy, last);
                else passed++;
                hold_left--;
            end else begin
                exp_y = model[4'(int'(addr) + got)];
                total++;
                if (valid !== 1'b1 || Y !== exp_y)
                    $display("FAIL scan_word%0d got Y=%h v=%b want %h 1",
                             got, Y, valid, exp_y);
                else passed++;
                total++;
                if (done !== (got == l - 1) || busy !== (got < l - 1))
                    $display("FAIL scan_flags%0d got d=%b b=%b want %b %b", got,
                             done, busy, got == l - 1, got < l - 1);
                else passed++;
                last = exp_y;
                got++;
                if (got == hold_after) hold_left = hold_n;
            end
            if (got >= l) break;
            we = (got == wr_at);
            Address = 4'd5;
            Din = 4'hF;
            hold = (hold_left > 0);
            was_held = hold;
            cyc();
            cycles++;
        end
        we = 1'b0;
        hold = 1'b0;
        if (got < l) begin
            total++;
            $display("FAIL scan_timeout got %0d words want %0d", got, l);
        end
        cyc();
        total++;
        if (valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0)
            $display("FAIL scan_end got v=%b d=%b b=%b want 0 0 0",
                     valid, done, busy);
        else passed++;
    endtask

    task automatic test_full_scan();
        test_scan(4'd0, 0, 0, 0, 5);
        Address = 4'd5;
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        total++;
        if (valid !== 1'b1 || Y !== 4'h1)
            $display("FAIL write_ignored got Y=%h v=%b want 1 1", Y, valid);
        else passed++;
    endtask

    task automatic test_reset_midscan();
        Address = 4'd8;
        Din = 4'h0;
        we = 1'b1;
        cyc();
        we = 1'b0;
        Address = 4'd4;
        scan_len = 5'd0;
        scan_start = 1'b1;
        cyc();
        scan_start = 1'b0;
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || valid !== 1'b0 || Y !== 4'h0)
            $display("FAIL midscan_reset got Y=%h v=%b b=%b want 0 0 0",
                     Y, valid, busy);
        else passed++;
        load_default();
        cyc();
        #2;
        rst_n = 1'b1;
        cyc();
        Address = 4'd8;
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        total++;
        if (valid !== 1'b1 || Y !== 4'hF)
            $display("FAIL restored8 got Y=%h v=%b want F 1", Y, valid);
        else passed++;
    endtask

    task automatic test_random();
        int op;
        logic [3:0] a;
        logic [3:0] d;
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 3));
            a = 4'($urandom);
            d = 4'($urandom);
            if (op == 3) begin
                test_scan(a, int'($urandom_range(0, 16)),
                          int'($urandom_range(1, 6)),
                          int'($urandom_range(0, 3)), -1);
            end else begin
                Address = a;
                Din = d;
                we = (op != 1);
                rd_en = (op != 0);
                cyc();
                we = 1'b0;
                rd_en = 1'b0;
                if (op != 1) model[a] = d;
                total++;
                if (valid !== (op != 0) || (op != 0 && Y !== model[a]))
                    $display("FAIL rand_op%0d got Y=%h v=%b want %h %b",
                             op, Y, valid, model[a], op != 0);
                else passed++;
            end
        end
    endtask

    initial begin
        passed = 0;
        total = 0;
        we = 1'b0;
        rd_en = 1'b0;
        scan_start = 1'b0;
        scan_len = 5'd0;
        hold = 1'b0;
        Address = 4'd0;
        Din = 4'd0;
        test_reset();
        test_read();
        test_write_read();
        test_scan(4'd14, 4, 0, 0, -1);
        test_scan(4'd14, 4, 2, 2, -1);
        test_scan(4'd9, 1, 0, 0, -1);
        test_full_scan();
        test_reset_midscan();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
